// File: rtl/cvp14_halt_monitor_if.sv
// CVP14 core-to-DRAM bus as seen by the end-of-test monitor.
// The master side is the core or bench; the slave side is the monitor.
interface cvp14_halt_monitor_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] Addr;
    logic              RD;
    logic              WR;
    logic              DumpReq;
    logic              DumpAck;

    modport master (
        output Addr,
        output RD,
        output WR,
        output DumpAck,
        input  DumpReq
    );

    modport slave (
        input  Addr,
        input  RD,
        input  WR,
        input  DumpAck,
        output DumpReq
    );
endinterface

// File: rtl/cvp14_halt_monitor.sv
// End-of-test monitor: halt-address or timeout detection, dump handshake,
// drain delay, sticky Finish and per-run saturating bus counters.
module cvp14_halt_monitor #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(16'hFFF3),
    parameter bit                REQ_ACCESS = 1'b0,
    parameter int                TIMEOUT    = 6000000,
    parameter int                CNT_W      = 32,
    parameter int                DRAIN      = 1
) (
    input  logic                 Clk1,
    input  logic                 Reset,
    input  logic                 Enable,
    cvp14_halt_monitor_if.slave  bus,
    output logic                 Halted,
    output logic                 TimedOut,
    output logic                 Finish,
    output logic [CNT_W-1:0]     CycleCount,
    output logic [CNT_W-1:0]     RdCount,
    output logic [CNT_W-1:0]     WrCount
);
    // Timeout uses its own counter so it still fires when CNT_W saturates early.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [TW-1:0] TO_VAL  = TW'(TIMEOUT);
    localparam logic [DW-1:0] DR_LOAD = DW'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DUMP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tcnt;
    logic [DW-1:0]   r_drain;

    logic            w_access;
    logic            w_match;
    logic [TW-1:0]   w_tcnt_nxt;
    logic [CNT_W-1:0] w_cyc_nxt;
    logic [CNT_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_wr_nxt;

    assign w_access   = bus.RD | bus.WR;
    assign w_match    = (bus.Addr == HALT_ADDR) && (!REQ_ACCESS || w_access);
    assign w_tcnt_nxt = r_tcnt + 1'b1;
    assign w_cyc_nxt  = (&CycleCount) ? CycleCount : CycleCount + 1'b1;
    assign w_rd_nxt   = (&RdCount) ? RdCount : RdCount + 1'b1;
    assign w_wr_nxt   = (&WrCount) ? WrCount : WrCount + 1'b1;

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_drain     <= '0;
            bus.DumpReq <= 1'b0;
            Halted      <= 1'b0;
            TimedOut    <= 1'b0;
            Finish      <= 1'b0;
            CycleCount  <= '0;
            RdCount     <= '0;
            WrCount     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (Enable) r_state <= S_RUN;
                end
                S_RUN: begin
                    r_tcnt     <= w_tcnt_nxt;
                    CycleCount <= w_cyc_nxt;
                    if (bus.RD) RdCount <= w_rd_nxt;
                    if (bus.WR) WrCount <= w_wr_nxt;
                    if (w_match) begin
                        Halted      <= 1'b1;
                        bus.DumpReq <= 1'b1;
                        r_state     <= S_DUMP;
                    end else if (w_tcnt_nxt == TO_VAL) begin
                        TimedOut    <= 1'b1;
                        bus.DumpReq <= 1'b1;
                        r_state     <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (bus.DumpAck) begin
                        bus.DumpReq <= 1'b0;
                        r_drain     <= DR_LOAD;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        Finish  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cvp14_halt_monitor.sv
// Directed bench for cvp14_halt_monitor: three parameterisations, scoreboard
// queue of expected values popped and asserted after each stimulus step.
module tb_cvp14_halt_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;

    cvp14_halt_monitor_if #(.ADDR_W(16)) b0 ();
    cvp14_halt_monitor_if #(.ADDR_W(16)) b1 ();
    cvp14_halt_monitor_if #(.ADDR_W(16)) b2 ();

    logic        h0, t0, f0;
    logic [31:0] cc0, rc0, wc0;
    logic        h1, t1, f1;
    logic [31:0] cc1, rc1, wc1;
    logic        h2, t2, f2;
    logic [3:0]  cc2, rc2, wc2;

    cvp14_halt_monitor #(
        .REQ_ACCESS(1'b0), .TIMEOUT(20), .CNT_W(32), .DRAIN(1)
    ) u0 (
        .Clk1(clk), .Reset(rst0), .Enable(en0), .bus(b0.slave),
        .Halted(h0), .TimedOut(t0), .Finish(f0),
        .CycleCount(cc0), .RdCount(rc0), .WrCount(wc0)
    );

    cvp14_halt_monitor #(
        .REQ_ACCESS(1'b1), .TIMEOUT(8), .CNT_W(32), .DRAIN(1)
    ) u1 (
        .Clk1(clk), .Reset(rst1), .Enable(en1), .bus(b1.slave),
        .Halted(h1), .TimedOut(t1), .Finish(f1),
        .CycleCount(cc1), .RdCount(rc1), .WrCount(wc1)
    );

    cvp14_halt_monitor #(
        .REQ_ACCESS(1'b0), .TIMEOUT(40), .CNT_W(4), .DRAIN(3)
    ) u2 (
        .Clk1(clk), .Reset(rst2), .Enable(en2), .bus(b2.slave),
        .Halted(h2), .TimedOut(t2), .Finish(f2),
        .CycleCount(cc2), .RdCount(rc2), .WrCount(wc2)
    );

    string       q_tag[$];
    logic [31:0] q_exp[$];
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int lat;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        q_tag.push_back(t);
        q_exp.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (q_exp.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL sb_empty: got %0h, no expected value queued", obs);
        end else begin
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            n_chk++;
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: got %0h expected %0h", t, obs, e);
            end
        end
    endtask

    function automatic logic get_req(input int sel);
        case (sel)
            0:       return b0.DumpReq;
            1:       return b1.DumpReq;
            default: return b2.DumpReq;
        endcase
    endfunction

    // Edges elapsed until DumpReq rises, bounded; an expiry returns the bound.
    task automatic wait_req(input int sel, input int bound, output int edges);
        edges = 0;
        while (get_req(sel) !== 1'b1 && edges < bound) begin
            tick(1);
            edges++;
        end
    endtask

    initial begin
        b0.Addr = '0; b0.RD = 0; b0.WR = 0; b0.DumpAck = 0;
        b1.Addr = '0; b1.RD = 0; b1.WR = 0; b1.DumpAck = 0;
        b2.Addr = '0; b2.RD = 0; b2.WR = 0; b2.DumpAck = 0;
        tick(2);

        // reset state
        push("rst_req", 0); push("rst_halt", 0); push("rst_to", 0);
        push("rst_fin", 0); push("rst_cyc", 0); push("rst_cyc4", 0);
        pop_chk(b0.DumpReq); pop_chk(h0); pop_chk(t0);
        pop_chk(f0); pop_chk(cc0); pop_chk({28'd0, cc2});

        // halt by address: enable at edge 1, match sampled at edge 11
        rst0 = 0; en0 = 1;
        tick(1);
        en0 = 0;
        tick(9);
        push("halt_pre_req", 0);
        pop_chk(b0.DumpReq);
        b0.Addr = 16'hFFF3;
        push("halt_req", 1); push("halt_halted", 1);
        push("halt_cyc", 10); push("halt_to", 0);
        tick(1);
        pop_chk(b0.DumpReq); pop_chk(h0); pop_chk(cc0); pop_chk(t0);
        b0.Addr = '0; b0.RD = 1;
        push("dump_hold_req", 1); push("frozen_cyc", 10); push("frozen_rd", 0);
        tick(2);
        pop_chk(b0.DumpReq); pop_chk(cc0); pop_chk(rc0);
        b0.DumpAck = 1;
        push("ack_req_drop", 0); push("ack_fin", 0);
        tick(1);
        b0.DumpAck = 0;
        pop_chk(b0.DumpReq); pop_chk(f0);
        push("halt_finish", 1); push("halt_sticky", 1);
        tick(1);
        pop_chk(f0); pop_chk(h0);
        b0.RD = 0;

        // timeout with RD held high
        rst0 = 1;
        tick(1);
        rst0 = 0; en0 = 1; b0.RD = 1;
        tick(1);
        en0 = 0;
        push("to_latency", 20);
        wait_req(0, 40, lat);
        pop_chk(lat);
        push("to_timedout", 1); push("to_halted", 0);
        push("to_cyc", 20); push("to_rd", 20); push("to_wr", 0);
        pop_chk(t0); pop_chk(h0); pop_chk(cc0); pop_chk(rc0); pop_chk(wc0);

        // reset while DumpReq is high
        rst0 = 1; b0.RD = 0;
        push("mid_rst_req", 0); push("mid_rst_to", 0);
        push("mid_rst_cyc", 0); push("mid_rst_rd", 0);
        tick(1);
        pop_chk(b0.DumpReq); pop_chk(t0); pop_chk(cc0); pop_chk(rc0);

        // fresh run; ack held high before DUMP is entered
        rst0 = 0; en0 = 1; b0.DumpAck = 1;
        tick(1);
        en0 = 0;
        tick(3);
        b0.Addr = 16'hFFF3;
        push("fresh_cyc", 4); push("fresh_halt", 1); push("fresh_req", 1);
        tick(1);
        pop_chk(cc0); pop_chk(h0); pop_chk(b0.DumpReq);
        b0.Addr = '0;
        push("min_dump_req", 0); push("min_dump_fin", 0);
        tick(1);
        pop_chk(b0.DumpReq); pop_chk(f0);
        b0.DumpAck = 0;
        push("fresh_finish", 1);
        tick(1);
        pop_chk(f0);

        // access qualification: address alone does not match
        rst1 = 0; en1 = 1; b1.Addr = 16'hFFF3;
        tick(1);
        en1 = 0;
        push("acc_idle_req", 0); push("acc_idle_halt", 0); push("acc_idle_cyc", 5);
        tick(5);
        pop_chk(b1.DumpReq); pop_chk(h1); pop_chk(cc1);
        b1.RD = 1;
        push("acc_halt", 1); push("acc_req", 1);
        push("acc_rd", 1); push("acc_cyc", 6);
        tick(1);
        pop_chk(h1); pop_chk(b1.DumpReq); pop_chk(rc1); pop_chk(cc1);
        b1.RD = 0;

        // match on the same cycle the timeout would fire
        rst1 = 1; b1.Addr = '0;
        tick(1);
        rst1 = 0; en1 = 1;
        tick(1);
        en1 = 0;
        push("sim_pre_req", 0); push("sim_pre_cyc", 7);
        tick(7);
        pop_chk(b1.DumpReq); pop_chk(cc1);
        b1.Addr = 16'hFFF3; b1.WR = 1;
        push("sim_halt", 1); push("sim_to", 0);
        push("sim_cyc", 8); push("sim_wr", 1);
        tick(1);
        pop_chk(h1); pop_chk(t1); pop_chk(cc1); pop_chk(wc1);
        b1.Addr = '0; b1.WR = 0;

        // 4-bit counters saturate, timeout at 40 still fires
        rst2 = 0; en2 = 1; b2.RD = 1;
        tick(1);
        en2 = 0;
        push("sat_cyc", 15); push("sat_rd", 15); push("sat_req", 0);
        tick(16);
        pop_chk({28'd0, cc2}); pop_chk({28'd0, rc2}); pop_chk(b2.DumpReq);
        push("sat_latency", 24);
        wait_req(2, 60, lat);
        pop_chk(lat);
        push("sat_to", 1); push("sat_halt", 0); push("sat_cyc_end", 15);
        pop_chk(t2); pop_chk(h2); pop_chk({28'd0, cc2});
        b2.RD = 0; b2.DumpAck = 1;
        push("drain_req", 0); push("drain_fin0", 0);
        tick(1);
        b2.DumpAck = 0;
        pop_chk(b2.DumpReq); pop_chk(f2);
        push("drain_fin1", 0);
        tick(1);
        pop_chk(f2);
        push("drain_fin2", 0);
        tick(1);
        pop_chk(f2);
        push("drain_fin3", 1);
        tick(1);
        pop_chk(f2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
